// File: rtl/reg_file_2r1w_pkg.sv
// Shared CPU register-file constants.
// Default widths and the hard-wired zero register.
package reg_file_2r1w_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Decode/writeback side bundle of the register file.
// master drives addresses and strobes, slave returns data.
interface reg_file_2r1w_if
  import reg_file_2r1w_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
);

  logic [ADDR_W-1:0] rs1_addr;
  logic [DATA_W-1:0] rs1_data;
  logic              rs1_busy;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs2_data;
  logic              rs2_busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_rd;

  modport master (
    output rs1_addr, rs2_addr,
    output wr_en, wr_addr, wr_data,
    output issue_en, issue_rd,
    input  rs1_data, rs1_busy,
    input  rs2_data, rs2_busy
  );

  modport slave (
    input  rs1_addr, rs2_addr,
    input  wr_en, wr_addr, wr_data,
    input  issue_en, issue_rd,
    output rs1_data, rs1_busy,
    output rs2_data, rs2_busy
  );

endinterface

// File: rtl/reg_file_2r1w_scoreboard.sv
// Per-register busy bits for RAW hazard detection.
// Issue sets, writeback clears, issue wins on collision.
module reg_scoreboard
  import reg_file_2r1w_pkg::*;
#(
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_en_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             rs1_res;
  logic             rs2_res;

  // next busy vector: set beats clear, r0 never busy
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_en_i && issue_rd_i == ADDR_W'(i))
        busy_d[i] = 1'b1;
      else if (wr_en_i && wr_addr_i == ADDR_W'(i))
        busy_d[i] = 1'b0;
    end
    if (ZERO_REG != 0)
      busy_d[REG_ZERO] = 1'b0;
  end

  // busy vector register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // a bypassed write this cycle resolves the hazard
  always_comb begin
    rs1_res = (BYPASS != 0) && wr_en_i
            && wr_addr_i == rs1_addr_i
            && !(issue_en_i && issue_rd_i == rs1_addr_i);
    rs2_res = (BYPASS != 0) && wr_en_i
            && wr_addr_i == rs2_addr_i
            && !(issue_en_i && issue_rd_i == rs2_addr_i);
    rs1_busy_o = busy_q[rs1_addr_i] && !rs1_res;
    rs2_busy_o = busy_q[rs2_addr_i] && !rs2_res;
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read one-write GPR file with write bypass.
// Busy tracking lives in reg_scoreboard.
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             reset,
  reg_file_2r1w_if.slave   rf
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_ok;

  // writes to the zero register are dropped
  always_comb begin
    wr_ok = rf.wr_en;
    if (ZERO_REG != 0 && rf.wr_addr == ADDR_W'(REG_ZERO))
      wr_ok = 1'b0;
    mem_d = mem_q;
    if (wr_ok)
      mem_d[rf.wr_addr] = rf.wr_data;
  end

  // storage array
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  end

  // read port 1: zero reg, then bypass, then array
  always_comb begin
    rf.rs1_data = mem_q[rf.rs1_addr];
    if (BYPASS != 0 && rf.wr_en
        && rf.wr_addr == rf.rs1_addr)
      rf.rs1_data = rf.wr_data;
    if (ZERO_REG != 0
        && rf.rs1_addr == ADDR_W'(REG_ZERO))
      rf.rs1_data = '0;
  end

  // read port 2: zero reg, then bypass, then array
  always_comb begin
    rf.rs2_data = mem_q[rf.rs2_addr];
    if (BYPASS != 0 && rf.wr_en
        && rf.wr_addr == rf.rs2_addr)
      rf.rs2_data = rf.wr_data;
    if (ZERO_REG != 0
        && rf.rs2_addr == ADDR_W'(REG_ZERO))
      rf.rs2_data = '0;
  end

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .issue_en_i(rf.issue_en),
    .issue_rd_i(rf.issue_rd),
    .wr_en_i   (rf.wr_en),
    .wr_addr_i (rf.wr_addr),
    .rs1_addr_i(rf.rs1_addr),
    .rs2_addr_i(rf.rs2_addr),
    .rs1_busy_o(rf.rs1_busy),
    .rs2_busy_o(rf.rs2_busy)
  );

endmodule
